// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory, single-ALU multi-cycle datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready and counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       I,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemR,
  output logic             MemW,
  output logic             Regdst,
  output logic             RegW,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic             illegal_op,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  // Handshake: mem_ready=1 in FETCH, MEM_RD or MEM_WR completes the access that
  // cycle; while it is 0 the FSM holds and keeps the request asserted.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_R = 3'd2,
    WB_R   = 3'd3,
    ADDR   = 3'd4,
    MEM_RD = 3'd5,
    WB_MEM = 3'd6,
    MEM_WR = 3'd7
  } state_t;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd3;
  localparam logic [5:0] OP_AND = 6'd5;
  localparam logic [5:0] OP_OR  = 6'd7;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_SW  = 6'd4;

  state_t     cur;
  logic [5:0] op_q;
  logic       is_rtype;
  logic       is_mem;
  logic       retire_raw;

  assign is_rtype = (I == OP_ADD) || (I == OP_SUB) || (I == OP_AND) || (I == OP_OR);
  assign is_mem   = (I == OP_LW) || (I == OP_SW);

  assign retire_raw = (cur == WB_R) || (cur == WB_MEM) || ((cur == MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= FETCH;
      op_q        <= 6'd0;
      instr_count <= '0;
    end else begin
      if (retire_raw) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      case (cur)
        FETCH:  if (mem_ready) cur <= DECODE;
        DECODE: begin
          op_q <= I;
          if (is_rtype)    cur <= EXEC_R;
          else if (is_mem) cur <= ADDR;
          else             cur <= FETCH;
        end
        EXEC_R: cur <= WB_R;
        WB_R:   cur <= FETCH;
        ADDR:   cur <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: if (mem_ready) cur <= WB_MEM;
        WB_MEM: cur <= FETCH;
        MEM_WR: if (mem_ready) cur <= FETCH;
        default: cur <= FETCH;
      endcase
    end
  end

  // Reset overrides every decoded output in the same cycle.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemR       = 1'b0;
    MemW       = 1'b0;
    Regdst     = 1'b0;
    RegW       = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUop      = 2'b00;
    illegal_op = 1'b0;
    retire     = 1'b0;
    state      = 3'd0;
    if (!reset) begin
      state = cur;
      case (cur)
        FETCH: begin
          MemR    = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: illegal_op = !(is_rtype || is_mem);
        EXEC_R: begin
          ALUSrcA = 1'b1;
          case (op_q)
            OP_SUB:  ALUop = 2'b01;
            OP_AND:  ALUop = 2'b10;
            OP_OR:   ALUop = 2'b11;
            default: ALUop = 2'b00;
          endcase
        end
        WB_R: begin
          Regdst = 1'b1;
          RegW   = 1'b1;
          retire = 1'b1;
        end
        ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_RD: begin
          MemR = 1'b1;
          IorD = 1'b1;
        end
        WB_MEM: begin
          RegW     = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
        end
        MEM_WR: begin
          MemW   = 1'b1;
          IorD   = 1'b1;
          retire = mem_ready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each instruction
// into its expected per-cycle trace, which is replayed against the DUT.
module tb_multicycle_controller;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    i_op;
  logic          mem_ready;
  logic          PCWrite, IRWrite, IorD, MemR, MemW, Regdst, RegW, MemtoReg, ALUSrcA;
  logic [1:0]    ALUSrcB, ALUop;
  logic          illegal_op, retire;
  logic [CW-1:0] instr_count;
  logic [2:0]    state;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .I(i_op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemR(MemR), .MemW(MemW),
    .Regdst(Regdst), .RegW(RegW), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .illegal_op(illegal_op), .retire(retire),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst;
    logic [5:0]    op;
    logic          mr;
    logic [17:0]   exp;
    logic [CW-1:0] cnt;
  } cyc_t;

  cyc_t cyc_q[$];
  int   model_cnt;
  int   checks;
  int   errors;
  int   cyc_no;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  // Field order: PCWrite IRWrite IorD MemR MemW Regdst RegW MemtoReg ALUSrcA ALUSrcB ALUop illegal retire state
  function automatic logic [17:0] pk(input logic [2:0] st, input logic pcw, input logic irw,
                                     input logic iord, input logic memr, input logic memw,
                                     input logic regdst, input logic regw, input logic m2r,
                                     input logic srca, input logic [1:0] srcb,
                                     input logic [1:0] aluop, input logic ill, input logic ret);
    return {pcw, irw, iord, memr, memw, regdst, regw, m2r, srca, srcb, aluop, ill, ret, st};
  endfunction

  function automatic logic [17:0] dut_outs();
    return {PCWrite, IRWrite, IorD, MemR, MemW, Regdst, RegW, MemtoReg, ALUSrcA,
            ALUSrcB, ALUop, illegal_op, retire, state};
  endfunction

  task automatic push(input logic rst, input logic [5:0] op, input logic mr, input logic [17:0] exp);
    cyc_t c;
    c.rst = rst;
    c.op  = op;
    c.mr  = mr;
    c.exp = exp;
    c.cnt = model_cnt[CW-1:0];
    cyc_q.push_back(c);
  endtask

  // Expand one instruction into its cycle trace; abort stops after one memory wait cycle.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
    logic [1:0] alu;
    for (int k = 0; k < fw; k++)
      push(1'b0, 6'($urandom), 1'b0, pk(3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
    push(1'b0, 6'($urandom), 1'b1, pk(3'd0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
    case (op)
      6'd1, 6'd3, 6'd5, 6'd7: begin
        alu = (op == 6'd1) ? 2'b00 : (op == 6'd3) ? 2'b01 : (op == 6'd5) ? 2'b10 : 2'b11;
        push(1'b0, op, 1'($urandom), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        push(1'b0, 6'($urandom), 1'($urandom), pk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 0, 0));
        push(1'b0, 6'($urandom), 1'($urandom), pk(3'd3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1));
        model_cnt++;
      end
      6'd2: begin
        push(1'b0, op, 1'($urandom), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        push(1'b0, 6'($urandom), 1'($urandom), pk(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        for (int k = 0; k < mw; k++) begin
          push(1'b0, 6'($urandom), 1'b0, pk(3'd5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
          if (abort) return;
        end
        push(1'b0, 6'($urandom), 1'b1, pk(3'd5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        push(1'b0, 6'($urandom), 1'($urandom), pk(3'd6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1));
        model_cnt++;
      end
      6'd4: begin
        push(1'b0, op, 1'($urandom), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        push(1'b0, 6'($urandom), 1'($urandom), pk(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0));
        for (int k = 0; k < mw; k++) begin
          push(1'b0, 6'($urandom), 1'b0, pk(3'd7, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
          if (abort) return;
        end
        push(1'b0, 6'($urandom), 1'b1, pk(3'd7, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
        model_cnt++;
      end
      default:
        push(1'b0, op, 1'($urandom), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
    endcase
  endtask

  task automatic add_reset(input int n);
    for (int k = 0; k < n; k++) begin
      push(1'b1, 6'($urandom), 1'($urandom), 18'd0);
      model_cnt = 0;
    end
  endtask

  initial begin
    cyc_t          c;
    logic [5:0]    op;
    logic [5:0]    ops[8];
    checks    = 0;
    errors    = 0;
    cyc_no    = 0;
    model_cnt = 0;
    ops = '{6'd1, 6'd3, 6'd5, 6'd7, 6'd2, 6'd4, 6'd2, 6'd4};

    reset     = 1'b1;
    i_op      = 6'd0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 32'(dut_outs()), 32'd0);
    check("reset_cnt", 32'(instr_count), 32'd0);

    // Directed: each R-type, lw with 2 wait states, sw, illegal, reset mid-store.
    add_instr(6'd1, 0, 0, 1'b0);
    add_instr(6'd3, 0, 0, 1'b0);
    add_instr(6'd5, 0, 0, 1'b0);
    add_instr(6'd7, 0, 0, 1'b0);
    add_instr(6'd2, 0, 2, 1'b0);
    add_instr(6'd4, 0, 0, 1'b0);
    add_instr(6'd63, 0, 0, 1'b0);
    add_instr(6'd4, 1, 3, 1'b1);
    add_reset(1);
    for (int n = 0; n < 5; n++) add_instr(6'd4, 0, 0, 1'b0);

    // Random mix with occasional illegal opcodes, wait states and resets.
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        add_instr(6'd2, $urandom_range(0, 2), 2, 1'b1);
        add_reset($urandom_range(1, 2));
      end else begin
        add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end
    end

    while (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      @(negedge clk);
      reset     = c.rst;
      i_op      = c.op;
      mem_ready = c.mr;
      #1;
      check("ctl", 32'(dut_outs()), 32'(c.exp));
      check("cnt", 32'(instr_count), 32'(c.cnt));
      cyc_no++;
    end
    @(negedge clk);
    #1;
    check("final_cnt", 32'(instr_count), 32'(model_cnt[CW-1:0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
